// File: rtl/stack_seq.sv
// stack_seq: operand-stack sequencer for the WASM core.
// Accepts one stack operation at a time, checks it against the current
// depth, and then walks the single-ported stack through the pop/push
// strobes that the operation needs. POP and POP2 results go back to the
// execute unit. DUP and SWAP keep their operands in local temporaries and
// write them back to the stack.
module stack_seq #(
   parameter int WIDTH   = 64,
   parameter int DEPTH   = 16,
   parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               op_valid,
   output logic               op_ready,
   input  logic [2:0]         op_code,
   input  logic [WIDTH-1:0]   op_data,
   output logic               res_valid,
   output logic [WIDTH-1:0]   res_a,
   output logic [WIDTH-1:0]   res_b,
   output logic               err,
   output logic [DEPTH_W-1:0] depth,
   output logic               stk_push,
   output logic               stk_pop,
   output logic [WIDTH-1:0]   stk_push_data,
   input  logic [WIDTH-1:0]   stk_pop_data
);

   localparam logic [2:0] OP_PUSH = 3'd0;
   localparam logic [2:0] OP_POP  = 3'd1;
   localparam logic [2:0] OP_POP2 = 3'd2;
   localparam logic [2:0] OP_DUP  = 3'd3;
   localparam logic [2:0] OP_SWAP = 3'd4;

   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
   localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
   localparam logic [DEPTH_W-1:0] DEPTH_TWO = DEPTH_W'(2);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_POP_A  = 3'd1,
      S_POP_B  = 3'd2,
      S_CAP    = 3'd3,
      S_PUSH_A = 3'd4,
      S_PUSH_B = 3'd5
   } state_t;

   // Legality of an operation given the current entry count. Anything that
   // would underflow or overflow the stack is refused before a strobe issues,
   // which is also what keeps the depth counter from ever wrapping.
   function automatic logic op_legal(input logic [2:0]         code,
                                     input logic [DEPTH_W-1:0] cur);
      logic ok;
      ok = 1'b0;
      case (code)
         OP_PUSH: ok = (cur < DEPTH_MAX);
         OP_POP:  ok = (cur >= DEPTH_ONE);
         OP_POP2: ok = (cur >= DEPTH_TWO);
         OP_DUP:  ok = (cur >= DEPTH_ONE) && (cur < DEPTH_MAX);
         OP_SWAP: ok = (cur >= DEPTH_TWO);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic               op_ready_q, op_ready_d;
   logic               res_valid_q, res_valid_d;
   logic               err_q, err_d;
   logic [WIDTH-1:0]   res_a_q, res_a_d;
   logic [WIDTH-1:0]   res_b_q, res_b_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               stk_push_q, stk_push_d;
   logic               stk_pop_q, stk_pop_d;
   logic [WIDTH-1:0]   stk_push_data_q, stk_push_data_d;
   logic [WIDTH-1:0]   tmp_a_q, tmp_a_d;
   logic [WIDTH-1:0]   tmp_b_q, tmp_b_d;

   // Next-state, strobe and capture logic; pulses default low every cycle.
   always_comb begin
      state_d         = state_q;
      op_d            = op_q;
      op_ready_d      = op_ready_q;
      res_valid_d     = 1'b0;
      err_d           = 1'b0;
      res_a_d         = res_a_q;
      res_b_d         = res_b_q;
      stk_push_d      = 1'b0;
      stk_pop_d       = 1'b0;
      stk_push_data_d = '0;
      tmp_a_d         = tmp_a_q;
      tmp_b_d         = tmp_b_q;

      // The counter follows the strobe that was on the stack this cycle.
      depth_d = depth_q;
      if (stk_push_q) begin
         depth_d = depth_q + DEPTH_ONE;
      end else if (stk_pop_q) begin
         depth_d = depth_q - DEPTH_ONE;
      end

      case (state_q)
         S_IDLE: begin
            if (op_valid && op_ready_q) begin
               if (op_legal(op_code, depth_q)) begin
                  op_d       = op_code;
                  op_ready_d = 1'b0;
                  if (op_code == OP_PUSH) begin
                     state_d         = S_PUSH_A;
                     stk_push_d      = 1'b1;
                     stk_push_data_d = op_data;
                  end else begin
                     state_d   = S_POP_A;
                     stk_pop_d = 1'b1;
                  end
               end else begin
                  // Rejected ops leave the sequencer idle and ready.
                  err_d = 1'b1;
               end
            end
         end

         S_POP_A: begin
            if ((op_q == OP_POP2) || (op_q == OP_SWAP)) begin
               state_d   = S_POP_B;
               stk_pop_d = 1'b1;
            end else begin
               state_d = S_CAP;
            end
         end

         S_POP_B: begin
            // Stack output now holds the original top of stack.
            tmp_b_d = stk_pop_data;
            if (op_q == OP_POP2) begin
               res_b_d = stk_pop_data;
            end
            state_d = S_CAP;
         end

         S_CAP: begin
            if ((op_q == OP_POP) || (op_q == OP_POP2)) begin
               res_a_d     = stk_pop_data;
               res_valid_d = 1'b1;
               op_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end else begin
               // DUP pushes the captured value twice; SWAP pushes the old
               // top first so that it ends up second from the top.
               tmp_a_d    = stk_pop_data;
               state_d    = S_PUSH_A;
               stk_push_d = 1'b1;
               if (op_q == OP_SWAP) begin
                  stk_push_data_d = tmp_b_q;
               end else begin
                  stk_push_data_d = stk_pop_data;
               end
            end
         end

         S_PUSH_A: begin
            if (op_q == OP_PUSH) begin
               op_ready_d = 1'b1;
               state_d    = S_IDLE;
            end else begin
               state_d         = S_PUSH_B;
               stk_push_d      = 1'b1;
               stk_push_data_d = tmp_a_q;
            end
         end

         S_PUSH_B: begin
            op_ready_d = 1'b1;
            state_d    = S_IDLE;
         end

         default: begin
            op_ready_d = 1'b1;
            state_d    = S_IDLE;
         end
      endcase
   end

   // Control and result registers; reset abandons any sequence in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         op_q            <= OP_PUSH;
         op_ready_q      <= 1'b1;
         res_valid_q     <= 1'b0;
         err_q           <= 1'b0;
         res_a_q         <= '0;
         res_b_q         <= '0;
         depth_q         <= '0;
         stk_push_q      <= 1'b0;
         stk_pop_q       <= 1'b0;
         stk_push_data_q <= '0;
      end else begin
         state_q         <= state_d;
         op_q            <= op_d;
         op_ready_q      <= op_ready_d;
         res_valid_q     <= res_valid_d;
         err_q           <= err_d;
         res_a_q         <= res_a_d;
         res_b_q         <= res_b_d;
         depth_q         <= depth_d;
         stk_push_q      <= stk_push_d;
         stk_pop_q       <= stk_pop_d;
         stk_push_data_q <= stk_push_data_d;
      end
   end

   // Operand temporaries are always written before being read in a sequence.
   always_ff @(posedge clk) begin
      tmp_a_q <= tmp_a_d;
      tmp_b_q <= tmp_b_d;
   end

   assign op_ready      = op_ready_q;
   assign res_valid     = res_valid_q;
   assign res_a         = res_a_q;
   assign res_b         = res_b_q;
   assign err           = err_q;
   assign depth         = depth_q;
   assign stk_push      = stk_push_q;
   assign stk_pop       = stk_pop_q;
   assign stk_push_data = stk_push_data_q;

endmodule

// File: doc/stack_seq.md
# stack_seq

Operand-stack sequencer for the WASM core. It accepts one stack operation at a time from the decode/execute stage and issues the cycle-by-cycle push/pop strobes that drive the single-ported `stack` block. It returns popped operands to the execute unit and tracks the stack depth. It flags underflow, overflow and illegal opcodes before any strobe reaches the stack.

## Interface
- `WIDTH`, 64: entry width. Must equal the stack's `st_width`.
- `DEPTH`, 16: stack capacity in entries. Must equal the stack's capacity.
- `DEPTH_W`, $clog2(DEPTH+1): width of the depth counter.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  operation request.
- `op_ready`  out  1  sequencer can accept an operation; high only in IDLE.
- `op_code`  in  3  0 PUSH, 1 POP, 2 POP2, 3 DUP, 4 SWAP, 5–7 illegal.
- `op_data`  in  WIDTH  PUSH operand; sampled at acceptance.
- `res_valid`  out  1  one-cycle pulse; `res_a`/`res_b` are valid.
- `res_a`  out  WIDTH  POP result, or the deeper operand of POP2.
- `res_b`  out  WIDTH  top-of-stack operand of POP2.
- `err`  out  1  one-cycle pulse; the accepted op was rejected.
- `depth`  out  DEPTH_W  current entry count.
- `stk_push`, `stk_pop`  out  1  strobes to the stack; never both high in the same cycle.
- `stk_push_data`  out  WIDTH  data to push.
- `stk_pop_data`  in  WIDTH  stack output; valid the cycle after `stk_pop` is high.

## Operation
- Acceptance: `op_valid && op_ready` at the edge ending cycle N. `op_code` and `op_data` are captured on that edge.
- All outputs are registered.
- Legality is checked at acceptance against `depth`:
  - PUSH requires depth < DEPTH.
  - POP requires depth ≥ 1.
  - POP2 and SWAP require depth ≥ 2.
  - DUP requires 1 ≤ depth ≤ DEPTH-1.
  - Codes 5–7 are always illegal.
- Rejected op:
  - `err` = 1 in cycle N+1.
  - No strobes, depth unchanged, `res_valid` stays 0.
  - State stays IDLE, so `op_ready` stays high and a new op can be accepted in N+1.
- FSM states: IDLE, POP_A, POP_B, CAP, PUSH_A, PUSH_B.
  - PUSH: IDLE→PUSH_A (`stk_push`, data=`op_data`)→IDLE.
  - POP: IDLE→POP_A (`stk_pop`)→CAP (capture `stk_pop_data` into `res_a`)→IDLE with `res_valid`.
  - POP2: IDLE→POP_A→POP_B (second `stk_pop`; capture top into `res_b`)→CAP (capture into `res_a`)→IDLE with `res_valid`.
  - DUP: IDLE→POP_A→CAP (capture into tmp)→PUSH_A (push tmp)→PUSH_B (push tmp)→IDLE.
  - SWAP: IDLE→POP_A→POP_B (tmp_b = top)→CAP (tmp_a)→PUSH_A (push tmp_b)→PUSH_B (push tmp_a)→IDLE. The original top ends up second.
- `depth` changes on the edge that ends each strobe cycle: +1 per push, −1 per pop. It never wraps, because legality checks guarantee this.
- `res_a` and `res_b` hold their values until the next capture. `res_b` is not updated by POP.
- `stk_push_data` is 0 whenever `stk_push` is 0.
- Reset values: state IDLE, `op_ready` 1, `res_valid` 0, `err` 0, `res_a`/`res_b` 0, `depth` 0, `stk_push`/`stk_pop` 0, `stk_push_data` 0.
- Reset mid-operation: the sequence is abandoned with no further strobes. The op is not replayed. `rst` must be asserted together with the stack's own reset so that the stack and `depth` agree.

## Timing
Cycles are counted from acceptance at the end of cycle N.

- PUSH:
  - `stk_push` in N+1.
  - `op_ready` back in N+2.
- POP:
  - `stk_pop` in N+1.
  - Data in N+2.
  - `res_valid` and `op_ready` in N+3.
- POP2:
  - `stk_pop` in N+1 and N+2.
  - Data in N+2 (→`res_b`) and N+3 (→`res_a`).
  - `res_valid` and `op_ready` in N+4.
- DUP:
  - `stk_pop` in N+1.
  - `stk_push` in N+3 and N+4.
  - `op_ready` in N+5.
- SWAP:
  - `stk_pop` in N+1 and N+2.
  - `stk_push` in N+4 and N+5.
  - `op_ready` in N+6.
- Error: `err` in N+1, `op_ready` never drops.
- Throughput: `op_ready` is low while busy; back-to-back ops start in the cycle `op_ready` returns.
- `res_valid` has no backpressure: the consumer must take it in its pulse cycle.

## Test plan
- Reset, then PUSH 0xA5A5A5A5A5A5A5A5 and PUSH 0x7B7B7B7B7B7B7B7B → `stk_push` pulses one cycle each, `depth` = 2, no `err`.
- POP2 on that stack → `res_b` = 0x7B7B…, `res_a` = 0xA5A5…, one `res_valid` pulse at N+4, `depth` = 0.
- PUSH 0x11…11, PUSH 0x22…22, SWAP, POP, POP:
  - First POP returns 0x11…11.
  - Second POP returns 0x22…22.
  - `depth` returns to 0.
- PUSH 0x99…99, DUP, POP2:
  - `res_a` = `res_b` = 0x99…99.
  - The DUP sequence shows exactly one pop and two pushes.
- Boundary errors:
  - From reset: POP → `err` at N+1, no strobes, `depth` stays 0.
  - Fill with 16 PUSHes, then a 17th PUSH or a DUP → `err`, `depth` stays 16.
  - Opcode 6 → `err`.
- Assert `rst` during SWAP at N+3 → strobes stop immediately, all outputs at reset values next cycle, `op_ready` = 1.
